// File: rtl/seq_match_pkg.sv
// Shared types and helpers for the sequence-match bank.
// Channel config struct is sized for the default symbol width and depth.
package seq_match_pkg;

    localparam int unsigned SEQ_SYM_W = 2;
    localparam int unsigned SEQ_DEPTH = 4;

    function automatic int unsigned len_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned SEQ_LEN_W = len_width(SEQ_DEPTH);

    typedef struct packed {
        logic [SEQ_SYM_W*SEQ_DEPTH-1:0] pat;
        logic [SEQ_LEN_W-1:0]           len;
        logic                           overlap;
    } chan_cfg_t;

    function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max);
        return (v >= max) ? max : v + 1;
    endfunction

endpackage

// File: rtl/seq_match_chan.sv
// One pattern channel: config, fill tracking, compare against the candidate
// history (incoming symbol plus shared history), match flop and saturating counter.
module seq_match_chan
    import seq_match_pkg::*;
#(
    parameter int unsigned SYM_W = SEQ_SYM_W,
    parameter int unsigned DEPTH = SEQ_DEPTH,
    parameter int unsigned CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SYM_W*(DEPTH-1)-1:0] hist,
    input  logic [SYM_W-1:0]           sym,
    input  logic                       sym_valid,
    input  logic                       cfg_we,
    input  chan_cfg_t                  cfg_wdata,
    input  logic                       clear_cnt,
    output logic                       match,
    output logic [CNT_W-1:0]           cnt
);

    localparam int unsigned LEN_W   = len_width(DEPTH);
    localparam int unsigned CNT_MAX = (2 ** CNT_W) - 1;

    chan_cfg_t              cfg;
    logic [LEN_W-1:0]       fill;
    logic [LEN_W-1:0]       fill_next;
    logic [LEN_W-1:0]       len_clamped;
    logic [SYM_W*DEPTH-1:0] cand;
    logic                   pat_eq;
    logic                   hit;

    assign cand = {hist, sym};

    always_comb begin
        fill_next   = LEN_W'(sat_inc(32'(fill), DEPTH));
        len_clamped = (cfg_wdata.len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : cfg_wdata.len;
        pat_eq      = 1'b1;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if ((k < int'(cfg.len)) &&
                (cand[k*SYM_W +: SYM_W] != cfg.pat[k*SYM_W +: SYM_W])) begin
                pat_eq = 1'b0;
            end
        end
        hit = sym_valid && (cfg.len != '0) && (fill_next >= cfg.len) && pat_eq;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cfg   <= '0;
            fill  <= '0;
            cnt   <= '0;
            match <= 1'b0;
        end else if (cfg_we) begin
            // A symbol arriving with the write is not credited to this channel.
            cfg.pat     <= cfg_wdata.pat;
            cfg.len     <= len_clamped;
            cfg.overlap <= cfg_wdata.overlap;
            fill        <= '0;
            cnt         <= '0;
            match       <= 1'b0;
        end else begin
            match <= hit;
            if (sym_valid) begin
                fill <= (hit && !cfg.overlap) ? '0 : fill_next;
            end
            if (clear_cnt) begin
                cnt <= '0;
            end else if (hit) begin
                cnt <= CNT_W'(sat_inc(32'(cnt), CNT_MAX));
            end
        end
    end

endmodule

// File: rtl/seq_match_bank.sv
// Multi-channel sequence recogniser: shared symbol history, config write
// decode, and one seq_match_chan per pattern channel.
module seq_match_bank
    import seq_match_pkg::*;
#(
    parameter int unsigned SYM_W   = SEQ_SYM_W,
    parameter int unsigned DEPTH   = SEQ_DEPTH,
    parameter int unsigned NUM_PAT = 2,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [SYM_W-1:0]                sym_i,
    input  logic                            sym_valid_i,
    input  logic                            cfg_we_i,
    input  logic [idx_width(NUM_PAT)-1:0]   cfg_idx_i,
    input  logic [SYM_W*DEPTH-1:0]          cfg_pat_i,
    input  logic [len_width(DEPTH)-1:0]     cfg_len_i,
    input  logic                            cfg_overlap_i,
    input  logic                            clear_cnt_i,
    output logic [NUM_PAT-1:0]              match_o,
    output logic [NUM_PAT*CNT_W-1:0]        match_cnt_o
);

    localparam int unsigned IDX_W = idx_width(NUM_PAT);

    // The oldest slot only ever shifts out, so DEPTH-1 slots are stored;
    // the incoming symbol completes the candidate window.
    logic [SYM_W*(DEPTH-1)-1:0] hist;
    chan_cfg_t                  cfg_wdata;

    assign cfg_wdata = '{pat: cfg_pat_i, len: cfg_len_i, overlap: cfg_overlap_i};

    always_ff @(posedge clk) begin
        if (!rst) begin
            hist <= '0;
        end else if (sym_valid_i) begin
            for (int k = int'(DEPTH) - 2; k > 0; k--) begin
                hist[k*SYM_W +: SYM_W] <= hist[(k-1)*SYM_W +: SYM_W];
            end
            hist[0 +: SYM_W] <= sym_i;
        end
    end

    for (genvar p = 0; p < int'(NUM_PAT); p++) begin : g_chan
        logic we;
        assign we = cfg_we_i && (cfg_idx_i == IDX_W'(p));

        seq_match_chan #(
            .SYM_W (SYM_W),
            .DEPTH (DEPTH),
            .CNT_W (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .hist      (hist),
            .sym       (sym_i),
            .sym_valid (sym_valid_i),
            .cfg_we    (we),
            .cfg_wdata (cfg_wdata),
            .clear_cnt (clear_cnt_i),
            .match     (match_o[p]),
            .cnt       (match_cnt_o[p*CNT_W +: CNT_W])
        );
    end

endmodule
